// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the radix-5 reorder blocks.
//   R5 / N25       : radix and frame length of the 25-point path
//   stages_t       : encoding of the Stages configuration input
//   rd_state_t     : read-side FSM state encoding
//   digit_rev_addr : maps read digits (p,q) to the buffer index 5q+p
package fft_reorder_pkg;

   localparam int R5  = 5;
   localparam int N25 = 25;

   typedef enum logic [1:0] {
      STG_OFF = 2'd0,
      STG_5   = 2'd1,
      STG_25  = 2'd2
   } stages_t;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_t;

   // Output position 5p+q fetches the sample written at natural index 5q+p.
   function automatic logic [4:0] digit_rev_addr(input logic [2:0] p, input logic [2:0] q);
      return 5'(R5 * int'(q) + int'(p));
   endfunction

endpackage

// File: rtl/scramble25_if.sv
// Streaming sample bus of the scramble25 block.
//   di_re/di_im/di_en : natural-order input samples and valid
//   Stages            : static order configuration (0/3 off, 1 pass, 2 scramble)
//   do_re/do_im/do_en : reordered output samples and valid
// master = sample source/sink side, slave = the reorder block.
interface scramble25_if #(parameter int WIDTH = 18);
   logic [WIDTH-1:0] di_re;
   logic [WIDTH-1:0] di_im;
   logic             di_en;
   logic [1:0]       Stages;
   logic [WIDTH-1:0] do_re;
   logic [WIDTH-1:0] do_im;
   logic             do_en;

   modport master (
      output di_re, di_im, di_en, Stages,
      input  do_re, do_im, do_en
   );

   modport slave (
      input  di_re, di_im, di_en, Stages,
      output do_re, do_im, do_en
   );
endinterface

// File: rtl/pp_ram25.sv
// Ping-pong sample buffer: two banks of 25 complex words.
//   clk          : clock
//   we/waddr/wdata : write port, address {bank, 5-bit index}
//   re/raddr/rdata : read port, same address form, one-cycle registered read
// Bank 1 index i is stored at word 25+i so the array holds exactly 50 words.
module pp_ram25
   import fft_reorder_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic               clk,
   input  logic               we,
   input  logic [5:0]         waddr,
   input  logic [2*WIDTH-1:0] wdata,
   input  logic               re,
   input  logic [5:0]         raddr,
   output logic [2*WIDTH-1:0] rdata
);

   logic [2*WIDTH-1:0] mem [0:2*N25-1];

   function automatic logic [5:0] word_index(input logic [5:0] a);
      return a[5] ? (6'(N25) + {1'b0, a[4:0]}) : {1'b0, a[4:0]};
   endfunction

   always_ff @(posedge clk) begin
      if (we) begin
         mem[word_index(waddr)] <= wdata;
      end
      if (re) begin
         rdata <= mem[word_index(raddr)];
      end
   end

endmodule

// File: rtl/scramble25.sv
// Base-5 digit-reversal reorder for 25-point radix-5 frames.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : scramble25_if slave (di_* in, Stages config, do_* out)
// Stages 1 passes samples through with one cycle of delay; Stages 2 buffers
// each 25-sample frame in one bank and reads it back in 5q+p order while the
// other bank fills; Stages 0/3 holds everything at zero.
module scramble25
   import fft_reorder_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic         clk,
   input  logic         rst,
   scramble25_if.slave  bus
);

   localparam logic [4:0] LAST_IDX   = 5'(N25 - 1);
   localparam logic [2:0] LAST_DIGIT = 3'(R5 - 1);

   logic            stg25;
   logic            start;

   logic [4:0]      wcnt_reg, wcnt_next;
   logic            wbank_reg, wbank_next;
   rd_state_t       state_reg, state_next;
   // Read position rcnt = 5p+q is kept as its two base-5 digits.
   logic [2:0]      p_reg, p_next;
   logic [2:0]      q_reg, q_next;
   logic            rbank_reg, rbank_next;

   logic                ram_we;
   logic [5:0]          ram_waddr;
   logic                ram_re;
   logic [5:0]          ram_raddr;
   logic [2*WIDTH-1:0]  ram_rdata;

   logic [WIDTH-1:0] do_re_reg;
   logic [WIDTH-1:0] do_im_reg;
   logic             do_en_reg;

   assign stg25 = (bus.Stages == STG_25);
   // Final sample of a frame is being written this cycle.
   assign start = stg25 && bus.di_en && (wcnt_reg == LAST_IDX);

   // Write side: natural order into the current write bank.
   always_comb begin
      wcnt_next  = wcnt_reg;
      wbank_next = wbank_reg;
      if (!stg25) begin
         wcnt_next  = '0;
         wbank_next = 1'b0;
      end else if (bus.di_en) begin
         if (wcnt_reg == LAST_IDX) begin
            wcnt_next  = '0;
            wbank_next = ~wbank_reg;
         end else begin
            wcnt_next = wcnt_reg + 5'd1;
         end
      end
   end

   // Read side: a start pulse always re-arms at position 0 of the bank just
   // filled, which also covers the back-to-back case at the end of a read.
   always_comb begin
      state_next = state_reg;
      p_next     = p_reg;
      q_next     = q_reg;
      rbank_next = rbank_reg;
      if (!stg25) begin
         state_next = IDLE;
         p_next     = '0;
         q_next     = '0;
         rbank_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_next = READ;
                  p_next     = '0;
                  q_next     = '0;
                  rbank_next = wbank_reg;
               end
            end
            READ: begin
               if (p_reg == LAST_DIGIT && q_reg == LAST_DIGIT) begin
                  p_next = '0;
                  q_next = '0;
                  if (start) begin
                     rbank_next = wbank_reg;
                  end else begin
                     state_next = IDLE;
                  end
               end else if (q_reg == LAST_DIGIT) begin
                  q_next = '0;
                  p_next = p_reg + 3'd1;
               end else begin
                  q_next = q_reg + 3'd1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_reg  <= '0;
         wbank_reg <= 1'b0;
         state_reg <= IDLE;
         p_reg     <= '0;
         q_reg     <= '0;
         rbank_reg <= 1'b0;
      end else begin
         wcnt_reg  <= wcnt_next;
         wbank_reg <= wbank_next;
         state_reg <= state_next;
         p_reg     <= p_next;
         q_reg     <= q_next;
         rbank_reg <= rbank_next;
      end
   end

   // The read address is issued from the next-state digits so the RAM word
   // for position (p,q) is already in ram_rdata while the FSM sits on it;
   // the output register then adds the second cycle of latency.
   assign ram_we    = stg25 && bus.di_en;
   assign ram_waddr = {wbank_reg, wcnt_reg};
   assign ram_re    = (state_next == READ);
   assign ram_raddr = {rbank_next, digit_rev_addr(p_next, q_next)};

   pp_ram25 #(
      .WIDTH (WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata ({bus.di_re, bus.di_im}),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         do_re_reg <= '0;
         do_im_reg <= '0;
         do_en_reg <= 1'b0;
      end else begin
         case (bus.Stages)
            STG_5: begin
               do_re_reg <= bus.di_re;
               do_im_reg <= bus.di_im;
               do_en_reg <= bus.di_en;
            end
            STG_25: begin
               do_en_reg <= (state_reg == READ);
               if (state_reg == READ) begin
                  do_re_reg <= ram_rdata[2*WIDTH-1:WIDTH];
                  do_im_reg <= ram_rdata[WIDTH-1:0];
               end else begin
                  do_re_reg <= '0;
                  do_im_reg <= '0;
               end
            end
            default: begin
               do_re_reg <= '0;
               do_im_reg <= '0;
               do_en_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.do_re = do_re_reg;
   assign bus.do_im = do_im_reg;
   assign bus.do_en = do_en_reg;

endmodule

// File: tb/tb_scramble25.sv
// Self-checking bench for scramble25: random and directed streams are
// compared against a frame-level model that schedules every expected output
// sample at its absolute cycle.
module tb_scramble25;
   localparam int W = 18;

   logic clk = 1'b0;
   logic rst;

   scramble25_if #(.WIDTH(W)) bus ();

   scramble25 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           en;
      bit           chk;
      logic [W-1:0] re;
      logic [W-1:0] im;
   } exp_t;

   exp_t              data_at [int];
   logic [2*W-1:0]    frame [$];
   int                cyc = 0;
   int                total_cnt = 0;
   int                bad_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Reference model. A sample presented in cycle t (sampled at the edge that
   // makes cyc = t+1) appears at t+1 in pass mode; a completed 25-sample frame
   // whose last sample is in cycle t appears at t+2..t+26, position k taking
   // natural index 5*(k%5)+k/5.
   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.Stages == 2'd1) begin
            data_at[cyc] = '{en: bus.di_en, chk: 1'b1, re: bus.di_re, im: bus.di_im};
         end else if (bus.Stages == 2'd2 && bus.di_en) begin
            frame.push_back({bus.di_re, bus.di_im});
            if (frame.size() == 25) begin
               for (int k = 0; k < 25; k++) begin
                  int src;
                  src = (k % 5) * 5 + k / 5;
                  data_at[cyc + 1 + k] = '{en: 1'b1, chk: 1'b1,
                                           re: frame[src][2*W-1:W], im: frame[src][W-1:0]};
               end
               frame.delete();
            end
         end
      end
   end

   always @(posedge rst) begin
      frame.delete();
      data_at.delete();
   end

   // Output monitor, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (data_at.exists(cyc)) begin
            exp_t e;
            e = data_at[cyc];
            check_val("do_en", 64'(bus.do_en), 64'(e.en));
            if (e.chk) begin
               check_val("do_re", 64'(bus.do_re), 64'(e.re));
               check_val("do_im", 64'(bus.do_im), 64'(e.im));
            end
            $display("cyc=%0d exp en=%0d re=%0d im=%0d", cyc, e.en, e.re, e.im);
            data_at.delete(cyc);
         end else begin
            check_val("do_en_quiet", 64'(bus.do_en), 64'd0);
            if (bus.Stages == 2'd0 || bus.Stages == 2'd3) begin
               check_val("off_re", 64'(bus.do_re), 64'd0);
               check_val("off_im", 64'(bus.do_im), 64'd0);
            end
         end
      end
   end

   task automatic drive(input bit en, input logic [W-1:0] re, input logic [W-1:0] im);
      @(negedge clk);
      bus.di_en = en;
      bus.di_re = re;
      bus.di_im = im;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0);
   endtask

   task automatic set_stages(input logic [1:0] s);
      idle(3);
      bus.Stages = s;
      idle(3);
   endtask

   task automatic rand_samples(input int count, input int gap_pct);
      int got;
      got = 0;
      while (got < count) begin
         if ($urandom_range(99) < gap_pct) begin
            drive(1'b0, W'($urandom), W'($urandom));
         end else begin
            drive(1'b1, W'($urandom), W'($urandom));
            got++;
         end
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_val("rst_do_en", 64'(bus.do_en), 64'd0);
      check_val("rst_do_re", 64'(bus.do_re), 64'd0);
      check_val("rst_do_im", 64'(bus.do_im), 64'd0);
      @(negedge clk);
      bus.di_en = 1'b0;
      bus.di_re = '0;
      bus.di_im = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      bus.di_en  = 1'b0;
      bus.di_re  = '0;
      bus.di_im  = '0;
      bus.Stages = 2'd0;
      #1;
      check_val("init_do_en", 64'(bus.do_en), 64'd0);
      check_val("init_do_re", 64'(bus.do_re), 64'd0);
      check_val("init_do_im", 64'(bus.do_im), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Pass-through: ramp 1..10, then random data with random valid.
      set_stages(2'd1);
      for (int i = 1; i <= 10; i++) drive(1'b1, W'(i), W'(i + 500));
      for (int i = 0; i < 20; i++) drive(1'($urandom_range(1)), W'($urandom), W'($urandom));

      // Scramble: contiguous ramp.
      set_stages(2'd2);
      for (int i = 0; i < 25; i++) drive(1'b1, W'(i), W'(i + 100));
      idle(30);

      // Same ramp with valid toggling.
      for (int i = 0; i < 25; i++) begin
         drive(1'b1, W'(i), W'(i + 100));
         drive(1'b0, '0, '0);
      end
      idle(30);

      // Two frames back-to-back.
      for (int i = 0; i < 25; i++) drive(1'b1, W'(i), W'(i + 100));
      for (int i = 100; i < 125; i++) drive(1'b1, W'(i), W'(i + 100));
      idle(30);

      // Random gapped frames.
      rand_samples(50, 40);
      idle(30);

      // Reset during a read with a partial frame pending.
      rand_samples(25, 0);
      rand_samples(12, 0);
      pulse_reset();
      rand_samples(25, 30);
      idle(30);

      // Disabled with live input, then scramble again.
      set_stages(2'd0);
      for (int i = 0; i < 40; i++) drive(1'b1, W'($urandom), W'($urandom));
      set_stages(2'd3);
      for (int i = 0; i < 10; i++) drive(1'b1, W'($urandom), W'($urandom));
      set_stages(2'd2);
      rand_samples(25, 20);
      idle(30);

      check_val("pending", 64'(data_at.num()), 64'd0);
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/scramble25.md
# scramble25

Input-side base-5 digit-reversal block for the radix-5 FFT path. It takes natural-order complex samples and emits them in base-5 digit-reversed order, so a frame that has been through `reorder25` can be scrambled again on the way back into a radix-5 stage. It supports the same `Stages` encoding as the output-side order selector and uses a 2×25-entry ping-pong buffer for continuous streaming.

## Interface
- `WIDTH`, 18, bit width of each real and imaginary component.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `di_re` input WIDTH: input sample, real part.
- `di_im` input WIDTH: input sample, imaginary part.
- `di_en` input 1: input sample valid; gaps allowed.
- `Stages` input 2: 0 gives zero output, 1 gives 5-point pass-through, 2 gives 25-point scramble, 3 is treated as 0.
- `do_re` output WIDTH: output sample, real part; registered.
- `do_im` output WIDTH: output sample, imaginary part; registered.
- `do_en` output 1: output sample valid; registered.

## Operation
- Reset: `do_re`, `do_im` and `do_en` go to 0. All of `wcnt`, `wbank`, `rcnt`, `rbank` and the FSM (IDLE) are cleared. Buffer contents are don't-care.
- Stages 0 or 3:
  - Outputs are held at 0.
  - Write and read counters are held at reset values.
  - `di_en` is ignored.
- Stages 1: `do_* <= di_*` and `do_en <= di_en` every cycle. This is a 1-cycle delay with no reordering, since a 1-digit reversal is the identity.
- Stages 2, write side:
  - Natural index n = 5a+b, with a and b in 0..4.
  - On each `di_en`, the sample is written to bank `wbank` at address `wcnt`, then `wcnt` increments.
  - When `wcnt`=24 is written, `wcnt` goes to 0, `wbank` toggles, and a start pulse is issued for the just-filled bank.
- Stages 2, read FSM:
  - IDLE to READ on the start pulse: `rbank` is set to the filled bank and `rcnt` to 0.
  - In READ, `rcnt` = 5p+q (p is the high digit, q the low digit). The buffer reads address 5q+p.
  - READ returns to IDLE after `rcnt`=24, unless a start pulse arrives in the same cycle. In that case it stays in READ with `rcnt` set to 0 and `rbank` toggled.
- Output: for a ramp input 0..24, the output order is 0,5,10,15,20,1,6,...,24.
- Overflow is impossible: a frame needs at least 25 enabled input cycles, and a read takes exactly 25 cycles.
- `Stages` is static configuration. Changing it while `wcnt`≠0 or while the FSM is in READ is illegal. The bench must change it only after reset or when idle.
- Arithmetic: none. Data passes through bit-exact.

## Timing
- Stages 1: latency is 1 cycle.
- Stages 2, single frame: the 25th `di_en` is in cycle t.
  - The FSM is in READ with `rcnt`=0 at t+1, and the buffer read is registered.
  - `do_en`=1 for cycles t+2 through t+26, exactly 25 consecutive cycles.
- Back-to-back frames with `di_en` held high: the output is continuous, 50 consecutive valid cycles for 2 frames with no bubble.
- Gapped input: gaps stretch the write phase only. Output bursts are always 25 contiguous cycles.
- Reset mid-frame or mid-read: takes effect immediately (asynchronous).
  - `do_en` drops to 0 at once.
  - The partial frame is discarded.
  - The next `di_en` after reset is sample 0 of a new frame, written to bank 0.
- Simultaneous write and read on the same address cannot occur because the write bank is always ≠ the read bank.

## Structure
- Shared package `fft_reorder_pkg`, holding:
  - the constants `R5`=5 and `N25`=25;
  - the `Stages` encodings `STG_OFF`=0, `STG_5`=1 and `STG_25`=2;
  - the FSM state encoding (IDLE, READ).
- Sub-module `pp_ram25`:
  - simple dual-port RAM with 50 words of 2×WIDTH bits;
  - one write port and one registered read port;
  - address is {bank, 5-bit index}.
- Top level contains the write counter, the read FSM, digit counters p/q and the output mux by `Stages`.

## Test plan
- Reset: assert `rst` mid-stream → `do_en`, `do_re` and `do_im` read 0 within the same cycle. After release, no `do_en` appears until 25 new samples have been entered.
- Stages=1, ramp 1..10 with `di_en`=1 → `do_re` = 1..10 delayed by exactly 1 cycle, and `do_en` mirrors `di_en` delayed by 1.
- Stages=2, ramp re=0..24 and im=100..124 contiguous → starting 2 cycles after the last input, 25 outputs re=0,5,10,15,20,1,6,11,16,21,...,4,9,14,19,24, with im equal to re+100.
- Stages=2, same ramp with `di_en` toggling 1,0,1,0... → identical output sequence, output contiguous, first `do_en` 2 cycles after the 25th accepted sample.
- Stages=2, two frames back-to-back (0..24 then 100..124) → 50 consecutive `do_en` cycles, the second frame re=100,105,...,124 with no gap.
- Stages=0 with an active ramp input → `do_en`=0 and outputs 0 throughout. Switching to 2 after idle then gives normal scramble behaviour.
